// File: rtl/drug_counter_pkg.sv
// Shared types and constants for the drug counter's keypad input path.
// Key codes are {row[1:0], col[1:0]} as seen by the column-scanned 4x4 keypad.
package drug_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEB,
      ST_HELD,
      ST_REL
   } kp_state_t;

   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_SINGLE,
      CLS_MULTI
   } frame_cls_t;

   // Keypad legend: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / CLR-0-ENT-D
   localparam logic [3:0] KEY_1   = 4'h0;
   localparam logic [3:0] KEY_2   = 4'h1;
   localparam logic [3:0] KEY_3   = 4'h2;
   localparam logic [3:0] KEY_A   = 4'h3;
   localparam logic [3:0] KEY_4   = 4'h4;
   localparam logic [3:0] KEY_5   = 4'h5;
   localparam logic [3:0] KEY_6   = 4'h6;
   localparam logic [3:0] KEY_B   = 4'h7;
   localparam logic [3:0] KEY_7   = 4'h8;
   localparam logic [3:0] KEY_8   = 4'h9;
   localparam logic [3:0] KEY_9   = 4'hA;
   localparam logic [3:0] KEY_C   = 4'hB;
   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_0   = 4'hD;
   localparam logic [3:0] KEY_ENT = 4'hE;
   localparam logic [3:0] KEY_D   = 4'hF;

   function automatic frame_cls_t classify(input logic [1:0] cnt);
      case (cnt)
         2'd0:    return CLS_NONE;
         2'd1:    return CLS_SINGLE;
         default: return CLS_MULTI;
      endcase
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: o_tick is high for one cycle every TICK_DIV clocks,
// on the last count of each period.
module tick_divider #(
   parameter int TICK_DIV = 100_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with frame-level debounce; emits one key_valid
// pulse per accepted press and tracks hold/release and multi-key frames.
module keypad_scan_debounce
   import drug_counter_pkg::*;
#(
   parameter int TICK_DIV       = 100_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [3:0] scan_in,
   output logic [3:0] scan_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);

   localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

   logic       w_tick;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [1:0] r_col_idx;
   logic [3:0] r_scan_out;
   logic [1:0] r_acc_cnt;
   logic [3:0] r_acc_code;

   kp_state_t  r_state;
   logic [3:0] r_deb_cnt;
   logic [3:0] r_cand;
   logic [3:0] r_key_code;
   logic       r_key_valid;
   logic       r_key_held;
   logic       r_multi_key;

   logic [3:0] w_rows_p;
   logic [2:0] w_col_pop;
   logic [2:0] w_sum;
   logic [1:0] w_frame_cnt;
   logic [1:0] w_row_idx;
   logic [3:0] w_frame_code;
   logic       w_frame_end;
   frame_cls_t w_cls;
   logic [3:0] w_cnt_inc;

   tick_divider #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_divider (
      .i_clk  (clk_in),
      .i_rst_n(rst),
      .o_tick (w_tick)
   );

   assign scan_out  = r_scan_out;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign multi_key = r_multi_key;

   // Rows are active-low; the lowest pressed row wins the code for this column.
   assign w_rows_p  = ~r_sync2;
   assign w_col_pop = {2'b00, w_rows_p[0]} + {2'b00, w_rows_p[1]}
                    + {2'b00, w_rows_p[2]} + {2'b00, w_rows_p[3]};
   assign w_sum     = {1'b0, r_acc_cnt} + w_col_pop;
   assign w_frame_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

   always_comb begin
      w_row_idx = 2'd0;
      if (w_rows_p[0])      w_row_idx = 2'd0;
      else if (w_rows_p[1]) w_row_idx = 2'd1;
      else if (w_rows_p[2]) w_row_idx = 2'd2;
      else if (w_rows_p[3]) w_row_idx = 2'd3;
   end

   assign w_frame_code = (|w_rows_p) ? {w_row_idx, r_col_idx} : r_acc_code;
   assign w_frame_end  = w_tick && (r_col_idx == 2'd3);
   assign w_cls        = classify(w_frame_cnt);
   assign w_cnt_inc    = r_deb_cnt + 4'd1;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_sync1    <= 4'b1111;
         r_sync2    <= 4'b1111;
         r_col_idx  <= 2'd0;
         r_scan_out <= 4'b1110;
         r_acc_cnt  <= 2'd0;
         r_acc_code <= 4'd0;
      end else begin
         r_sync1 <= scan_in;
         r_sync2 <= r_sync1;
         if (w_tick) begin
            r_col_idx  <= r_col_idx + 2'd1;
            r_scan_out <= {r_scan_out[2:0], r_scan_out[3]};
            if (w_frame_end) begin
               r_acc_cnt  <= 2'd0;
               r_acc_code <= 4'd0;
            end else begin
               r_acc_cnt  <= w_frame_cnt;
               r_acc_code <= w_frame_code;
            end
         end
      end
   end

   // Debounce FSM: every decision is taken on the frame-end tick only.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_deb_cnt   <= 4'd0;
         r_cand      <= 4'd0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_multi_key <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_frame_end) begin
            r_multi_key <= (w_cls == CLS_MULTI);
            case (r_state)
               ST_IDLE: begin
                  if (w_cls == CLS_SINGLE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        r_key_code  <= w_frame_code;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_deb_cnt   <= 4'd0;
                        r_state     <= ST_HELD;
                     end else begin
                        r_cand    <= w_frame_code;
                        r_deb_cnt <= 4'd1;
                        r_state   <= ST_DEB;
                     end
                  end
               end
               ST_DEB: begin
                  if (w_cls == CLS_SINGLE && w_frame_code == r_cand) begin
                     if (w_cnt_inc == DEB_N) begin
                        r_key_code  <= r_cand;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_deb_cnt   <= 4'd0;
                        r_state     <= ST_HELD;
                     end else begin
                        r_deb_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_deb_cnt <= 4'd0;
                     r_state   <= ST_IDLE;
                  end
               end
               ST_HELD: begin
                  if (w_cls == CLS_NONE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        r_key_held <= 1'b0;
                        r_deb_cnt  <= 4'd0;
                        r_state    <= ST_IDLE;
                     end else begin
                        r_deb_cnt <= 4'd1;
                        r_state   <= ST_REL;
                     end
                  end
               end
               ST_REL: begin
                  if (w_cls == CLS_NONE) begin
                     if (w_cnt_inc == DEB_N) begin
                        r_key_held <= 1'b0;
                        r_deb_cnt  <= 4'd0;
                        r_state    <= ST_IDLE;
                     end else begin
                        r_deb_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_deb_cnt <= 4'd0;
                     r_state   <= ST_HELD;
                  end
               end
               default: begin
                  r_deb_cnt <= 4'd0;
                  r_state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce with a behavioural 4x4 keypad
// model; expected key events are queued by stimulus and popped by a monitor.
module tb_keypad_scan_debounce;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 2;
   localparam int FRAME    = 4 * TICK_DIV;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [3:0]  scan_in;
   logic [3:0]  scan_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        multi_key;
   logic [15:0] keys;

   int gcyc  = 0;
   int ph    = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   keypad_scan_debounce #(
      .TICK_DIV      (TICK_DIV),
      .DEBOUNCE_SCANS(DEB)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .scan_in  (scan_in),
      .scan_out (scan_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held),
      .multi_key(multi_key)
   );

   always #5 clk_in = ~clk_in;

   // Keypad: a pressed key at {r,c} pulls row r low while column c is driven low.
   always_comb begin
      scan_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!scan_out[c] && keys[r*4 + c]) scan_in[r] = 1'b0;
   end

   // Cycle position inside the scan frame; 16 marks the frame-end edge.
   always @(posedge clk_in) begin
      gcyc <= gcyc + 1;
      if (!rst) ph <= 0;
      else      ph <= (ph == FRAME) ? 1 : ph + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, gcyc);
      end
   endtask

   task automatic push_event(input logic [3:0] code, input int nframes);
      exp_t e;
      e.code = code;
      e.cyc  = gcyc + FRAME * nframes;
      exp_q.push_back(e);
   endtask

   task automatic wait_frame();
      int k;
      k = 0;
      do begin
         @(negedge clk_in);
         k++;
      end while (ph != FRAME && k < 3 * FRAME);
      if (ph != FRAME) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_wait: phase %0d, want %0d", ph, FRAME);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_scan_out"},  scan_out, 4'b1110);
      check({tag, "_key_code"},  key_code, 4'h0);
      check({tag, "_key_valid"}, key_valid, 1'b0);
      check({tag, "_key_held"},  key_held, 1'b0);
      check({tag, "_multi_key"}, multi_key, 1'b0);
   endtask

   // Monitor: every key_valid pulse must match the head of the scoreboard.
   always @(negedge clk_in) begin
      exp_t e;
      if (exp_q.size() > 0 && gcyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_key_valid: no pulse, want code %0h at cycle %0d", e.code, e.cyc);
      end
      if (key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_key_valid: pulse with code %0h at cycle %0d, want none", key_code, gcyc);
         end else begin
            e = exp_q.pop_front();
            check("event_code",  key_code, e.code);
            check("event_cycle", gcyc, e.cyc);
            check("event_held",  key_held, 1'b1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_so;
      rst  = 1'b0;
      keys = 16'h0000;
      repeat (3) @(negedge clk_in);
      check_reset_vals("rst");

      // Column walk after reset release, each column held TICK_DIV cycles
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_in);
         exp_so = ~(4'b0001 << ((k / TICK_DIV) % 4));
         check("scan_seq", scan_out, exp_so);
      end
      wait_frame();

      // Stable press of row 2 / column 1
      keys[9] = 1'b1;
      push_event(4'h9, 2);
      wait_frame();
      check("t2_held_early", key_held, 1'b0);
      wait_frame();
      check("t2_held", key_held, 1'b1);
      check("t2_code", key_code, 4'h9);
      repeat (10) wait_frame();
      check("t2_still_held", key_held, 1'b1);
      check("t2_still_code", key_code, 4'h9);
      keys = 16'h0000;
      repeat (2) wait_frame();
      check("t2_released", key_held, 1'b0);

      // One-frame bounce is rejected
      keys[5] = 1'b1;
      wait_frame();
      keys = 16'h0000;
      repeat (2) wait_frame();
      check("t3_code", key_code, 4'h9);
      check("t3_held", key_held, 1'b0);

      // Release glitch while held does not re-trigger
      keys[6] = 1'b1;
      push_event(4'h6, 2);
      repeat (2) wait_frame();
      check("t4_held", key_held, 1'b1);
      check("t4_code", key_code, 4'h6);
      keys = 16'h0000;
      wait_frame();
      check("t4_rel1", key_held, 1'b1);
      keys[6] = 1'b1;
      wait_frame();
      check("t4_repress", key_held, 1'b1);
      keys = 16'h0000;
      wait_frame();
      check("t4_rel_a", key_held, 1'b1);
      wait_frame();
      check("t4_rel_b", key_held, 1'b0);

      // Two keys at once from idle
      keys[0] = 1'b1;
      keys[5] = 1'b1;
      wait_frame();
      check("t5_multi", multi_key, 1'b1);
      repeat (2) wait_frame();
      check("t5_multi_stay", multi_key, 1'b1);
      check("t5_no_held", key_held, 1'b0);
      check("t5_code_kept", key_code, 4'h6);
      keys = 16'h0000;
      wait_frame();
      check("t5_multi_clr", multi_key, 1'b0);

      // Second key added while one is held
      keys[9] = 1'b1;
      push_event(4'h9, 2);
      repeat (2) wait_frame();
      check("t5_held9", key_held, 1'b1);
      check("t5_code9", key_code, 4'h9);
      check("t5_single", multi_key, 1'b0);
      keys[3] = 1'b1;
      repeat (2) wait_frame();
      check("t5_multi_held", multi_key, 1'b1);
      check("t5_code_stay", key_code, 4'h9);
      check("t5_held_stay", key_held, 1'b1);
      keys = 16'h0000;
      repeat (2) wait_frame();
      check("t5_rel_held", key_held, 1'b0);
      check("t5_rel_multi", multi_key, 1'b0);

      // Reset pulse one frame into debounce
      keys[9] = 1'b1;
      wait_frame();
      check("t6_deb_held", key_held, 1'b0);
      repeat (5) @(negedge clk_in);
      rst = 1'b0;
      #1;
      check_reset_vals("t6_rst");
      @(negedge clk_in);
      rst = 1'b1;
      push_event(4'h9, 2);
      wait_frame();
      check("t6_code_early", key_code, 4'h0);
      check("t6_held_early", key_held, 1'b0);
      wait_frame();
      check("t6_held", key_held, 1'b1);
      check("t6_code", key_code, 4'h9);
      keys = 16'h0000;
      repeat (2) wait_frame();
      check("t6_released", key_held, 1'b0);

      repeat (2) @(negedge clk_in);
      check("events_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
